// File: rtl/mem_pkg.sv
// Shared types, aluop encodings and decode helpers for the MEM stage.
package mem_pkg;

  localparam int unsigned MEM_ALUOP_W = 8;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned REG_AW      = 5;
  localparam int unsigned STRB_W      = 4;

  localparam logic [MEM_ALUOP_W-1:0] ALUOP_LDB  = 8'h20;
  localparam logic [MEM_ALUOP_W-1:0] ALUOP_LDH  = 8'h21;
  localparam logic [MEM_ALUOP_W-1:0] ALUOP_LDW  = 8'h22;
  localparam logic [MEM_ALUOP_W-1:0] ALUOP_LDBU = 8'h23;
  localparam logic [MEM_ALUOP_W-1:0] ALUOP_LDHU = 8'h24;
  localparam logic [MEM_ALUOP_W-1:0] ALUOP_STB  = 8'h28;
  localparam logic [MEM_ALUOP_W-1:0] ALUOP_STH  = 8'h29;
  localparam logic [MEM_ALUOP_W-1:0] ALUOP_STW  = 8'h2A;

  typedef enum logic [3:0] {
    NONE, LDB, LDH, LDW, LDBU, LDHU, STB, STH, STW
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DRAIN
  } mem_state_e;

  // Registered writeback payload toward WB (also mirrored on the forward bus).
  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic [REG_AW-1:0] waddr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] pc;
    logic              excp;
    logic              ale;
    logic              is_load;
  } wb_t;

  // Access latched at accept time and held while the cache is busy.
  typedef struct packed {
    mem_op_e           op;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [WORD_W-1:0] wdata;
    logic              wreg;
    logic [REG_AW-1:0] waddr;
    logic [WORD_W-1:0] pc;
  } acc_t;

  function automatic mem_op_e decode_aluop(input logic [MEM_ALUOP_W-1:0] aluop);
    mem_op_e op;
    case (aluop)
      ALUOP_LDB:  op = LDB;
      ALUOP_LDH:  op = LDH;
      ALUOP_LDW:  op = LDW;
      ALUOP_LDBU: op = LDBU;
      ALUOP_LDHU: op = LDHU;
      ALUOP_STB:  op = STB;
      ALUOP_STH:  op = STH;
      ALUOP_STW:  op = STW;
      default:    op = NONE;
    endcase
    return op;
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == STB) || (op == STH) || (op == STW);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store strobes/replication, load extension, misalignment.
module mem_align
  import mem_pkg::*;
(
  input  mem_op_e           op,
  input  logic [1:0]        addr_lo,
  input  logic [WORD_W-1:0] sdata,
  input  logic [WORD_W-1:0] rdata,
  output logic [STRB_W-1:0] wstrb,
  output logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] ldata,
  output logic              misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half out of the raw load word.
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Per-op formatting and alignment check.
  always_comb begin
    wstrb      = '0;
    wdata      = sdata;
    ldata      = rdata;
    misaligned = 1'b0;
    case (op)
      LDB:  ldata = {{24{byte_sel[7]}}, byte_sel};
      LDBU: ldata = {24'd0, byte_sel};
      LDH: begin
        ldata      = {{16{half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      LDHU: begin
        ldata      = {16'd0, half_sel};
        misaligned = addr_lo[0];
      end
      LDW:  misaligned = |addr_lo;
      STB: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{sdata[7:0]}};
      end
      STH: begin
        wstrb      = 4'b0011 << addr_lo;
        wdata      = {2{sdata[15:0]}};
        misaligned = addr_lo[0];
      end
      STW: begin
        wstrb      = 4'b1111;
        misaligned = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-cache access FSM, registered writeback and forward bus.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned ALUOP_W = 8,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid_i,
  input  logic [ALUOP_W-1:0] ex_aluop_i,
  input  logic [ADDR_W-1:0]  ex_mem_addr_i,
  input  logic [ADDR_W-1:0]  ex_store_data_i,
  input  logic               ex_wreg_i,
  input  logic [4:0]         ex_waddr_i,
  input  logic [ADDR_W-1:0]  ex_wdata_i,
  input  logic [ADDR_W-1:0]  ex_pc_i,
  input  logic               ex_excp_i,
  input  logic               flush_i,
  output logic               dcache_req_valid_o,
  input  logic               dcache_req_ready_i,
  output logic               dcache_req_we_o,
  output logic [ADDR_W-1:0]  dcache_req_addr_o,
  output logic [3:0]         dcache_req_wstrb_o,
  output logic [ADDR_W-1:0]  dcache_req_wdata_o,
  input  logic               dcache_resp_valid_i,
  input  logic [ADDR_W-1:0]  dcache_resp_data_i,
  output logic               wb_valid_o,
  output logic               wb_wreg_o,
  output logic [4:0]         wb_waddr_o,
  output logic [ADDR_W-1:0]  wb_wdata_o,
  output logic [ADDR_W-1:0]  wb_pc_o,
  output logic               wb_excp_o,
  output logic               wb_ale_o,
  output logic               fwd_write_reg_o,
  output logic               fwd_is_load_data_o,
  output logic [4:0]         fwd_waddr_o,
  output logic [ADDR_W-1:0]  fwd_wdata_o,
  output logic               stallreq_o
);

  mem_state_e        state_q, state_d;
  wb_t               wb_q, wb_d;
  acc_t              acc_q, acc_d;
  mem_op_e           ex_op, al_op;
  logic [1:0]        al_lo;
  logic [STRB_W-1:0] al_wstrb;
  logic [WORD_W-1:0] al_wdata, al_ldata;
  logic              al_mis;

  assign ex_op = decode_aluop(MEM_ALUOP_W'(ex_aluop_i));
  // In IDLE the aligner formats the incoming op; otherwise it extends the held load.
  assign al_op = (state_q == IDLE) ? ex_op : acc_q.op;
  assign al_lo = (state_q == IDLE) ? ex_mem_addr_i[1:0] : acc_q.addr[1:0];

  mem_align u_align (
    .op         (al_op),
    .addr_lo    (al_lo),
    .sdata      (ex_store_data_i),
    .rdata      (dcache_resp_data_i),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .ldata      (al_ldata),
    .misaligned (al_mis)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    wb_d          = wb_q;
    wb_d.valid    = 1'b0;
    wb_d.is_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid_i && !flush_i) begin
          if (ex_excp_i || (ex_op == NONE) || al_mis) begin
            wb_d.valid = 1'b1;
            wb_d.wreg  = ex_wreg_i & ~(ex_excp_i | al_mis);
            wb_d.waddr = ex_waddr_i;
            wb_d.wdata = ex_wdata_i;
            wb_d.pc    = ex_pc_i;
            wb_d.excp  = ex_excp_i | al_mis;
            wb_d.ale   = al_mis & ~ex_excp_i;
          end else begin
            acc_d.op    = ex_op;
            acc_d.we    = is_store(ex_op);
            acc_d.addr  = ex_mem_addr_i;
            acc_d.wstrb = al_wstrb;
            acc_d.wdata = al_wdata;
            acc_d.wreg  = ex_wreg_i;
            acc_d.waddr = ex_waddr_i;
            acc_d.pc    = ex_pc_i;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (dcache_req_ready_i) begin
          if (acc_q.we) begin
            state_d = IDLE;
            if (!flush_i) begin
              // Stores are posted: retire on the handshake.
              wb_d.valid = 1'b1;
              wb_d.wreg  = 1'b0;
              wb_d.waddr = acc_q.waddr;
              wb_d.wdata = '0;
              wb_d.pc    = acc_q.pc;
              wb_d.excp  = 1'b0;
              wb_d.ale   = 1'b0;
            end
          end else begin
            state_d = flush_i ? DRAIN : WAIT;
          end
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (flush_i) begin
          state_d = dcache_resp_valid_i ? IDLE : DRAIN;
        end else if (dcache_resp_valid_i) begin
          state_d      = IDLE;
          wb_d.valid   = 1'b1;
          wb_d.wreg    = acc_q.wreg;
          wb_d.waddr   = acc_q.waddr;
          wb_d.wdata   = al_ldata;
          wb_d.pc      = acc_q.pc;
          wb_d.excp    = 1'b0;
          wb_d.ale     = 1'b0;
          wb_d.is_load = 1'b1;
        end
      end
      DRAIN: begin
        if (dcache_resp_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, held access and writeback registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      wb_q    <= wb_d;
    end
  end

  assign stallreq_o         = (state_q != IDLE);
  assign dcache_req_valid_o = (state_q == REQ);
  assign dcache_req_we_o    = acc_q.we;
  assign dcache_req_addr_o  = {acc_q.addr[WORD_W-1:2], 2'b00};
  assign dcache_req_wstrb_o = acc_q.wstrb;
  assign dcache_req_wdata_o = acc_q.wdata;

  assign wb_valid_o         = wb_q.valid;
  assign wb_wreg_o          = wb_q.wreg;
  assign wb_waddr_o         = wb_q.waddr;
  assign wb_wdata_o         = wb_q.wdata;
  assign wb_pc_o            = wb_q.pc;
  assign wb_excp_o          = wb_q.excp;
  assign wb_ale_o           = wb_q.ale;

  assign fwd_write_reg_o    = wb_q.valid & wb_q.wreg;
  assign fwd_is_load_data_o = wb_q.valid & wb_q.is_load;
  assign fwd_waddr_o        = wb_q.waddr;
  assign fwd_wdata_o        = wb_q.wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized transaction bench for mem_access_stage with a byte-arithmetic reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic [7:0]  ex_aluop_i = '0;
  logic [31:0] ex_mem_addr_i = '0, ex_store_data_i = '0, ex_wdata_i = '0, ex_pc_i = '0;
  logic        ex_wreg_i = 1'b0, ex_excp_i = 1'b0, flush_i = 1'b0;
  logic [4:0]  ex_waddr_i = '0;
  logic        dcache_req_ready_i = 1'b0, dcache_resp_valid_i = 1'b0;
  logic [31:0] dcache_resp_data_i = '0;
  logic        dcache_req_valid_o, dcache_req_we_o;
  logic [31:0] dcache_req_addr_o, dcache_req_wdata_o;
  logic [3:0]  dcache_req_wstrb_o;
  logic        wb_valid_o, wb_wreg_o, wb_excp_o, wb_ale_o;
  logic [4:0]  wb_waddr_o, fwd_waddr_o;
  logic [31:0] wb_wdata_o, wb_pc_o, fwd_wdata_o;
  logic        fwd_write_reg_o, fwd_is_load_data_o, stallreq_o;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  localparam int F_NONE = 0, F_IDLE = 1, F_REQ_NOHS = 2, F_REQ_HS = 3, F_WAIT = 4, F_WAIT_RESP = 5;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_aluop_i(ex_aluop_i), .ex_mem_addr_i(ex_mem_addr_i),
    .ex_store_data_i(ex_store_data_i), .ex_wreg_i(ex_wreg_i), .ex_waddr_i(ex_waddr_i),
    .ex_wdata_i(ex_wdata_i), .ex_pc_i(ex_pc_i), .ex_excp_i(ex_excp_i), .flush_i(flush_i),
    .dcache_req_valid_o(dcache_req_valid_o), .dcache_req_ready_i(dcache_req_ready_i),
    .dcache_req_we_o(dcache_req_we_o), .dcache_req_addr_o(dcache_req_addr_o),
    .dcache_req_wstrb_o(dcache_req_wstrb_o), .dcache_req_wdata_o(dcache_req_wdata_o),
    .dcache_resp_valid_i(dcache_resp_valid_i), .dcache_resp_data_i(dcache_resp_data_i),
    .wb_valid_o(wb_valid_o), .wb_wreg_o(wb_wreg_o), .wb_waddr_o(wb_waddr_o),
    .wb_wdata_o(wb_wdata_o), .wb_pc_o(wb_pc_o), .wb_excp_o(wb_excp_o), .wb_ale_o(wb_ale_o),
    .fwd_write_reg_o(fwd_write_reg_o), .fwd_is_load_data_o(fwd_is_load_data_o),
    .fwd_waddr_o(fwd_waddr_o), .fwd_wdata_o(fwd_wdata_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Op table: 0 = ALU, 1 LD.B, 2 LD.H, 3 LD.W, 4 LD.BU, 5 LD.HU, 6 ST.B, 7 ST.H, 8 ST.W.
  function automatic logic [7:0] op_code(input int k);
    case (k)
      1: return 8'h20; 2: return 8'h21; 3: return 8'h22; 4: return 8'h23;
      5: return 8'h24; 6: return 8'h28; 7: return 8'h29; 8: return 8'h2A;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int op_size(input int k);
    if (k == 1 || k == 4 || k == 6) return 1;
    if (k == 2 || k == 5 || k == 7) return 2;
    return 4;
  endfunction

  function automatic bit op_load(input int k);   return (k >= 1 && k <= 5); endfunction
  function automatic bit op_store(input int k);  return (k >= 6);           endfunction
  function automatic bit op_signed(input int k); return (k == 1 || k == 2); endfunction

  function automatic logic [31:0] exp_load(input int k, input logic [31:0] addr, input logic [31:0] word);
    int unsigned     bits = 32'(op_size(k) * 8);
    longint unsigned v    = 64'(word) >> ((addr % 4) * 8);
    v = v % (64'd1 << bits);
    if (op_signed(k) && v >= (64'd1 << (bits - 1))) v = v + (64'd1 << 32) - (64'd1 << bits);
    return 32'(v);
  endfunction

  function automatic logic [3:0] exp_strb(input int k, input logic [31:0] addr);
    return 4'(((1 << op_size(k)) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input int k, input logic [31:0] data);
    if (op_size(k) == 1) return (data % 256) * 32'h0101_0101;
    if (op_size(k) == 2) return (data % 65536) * 32'h0001_0001;
    return data;
  endfunction

  // One instruction through MEM; ready/response/flush timing chosen by the caller.
  task automatic run_txn(input int k, input bit exc, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] alu, input logic [31:0] rword,
                         input int rd, input int rsp_d, input int fl, input int fpos);
    logic [4:0]  waddr = 5'($urandom);
    logic        wreg  = 1'($urandom);
    logic [31:0] pc    = $urandom;
    bit          mem   = (k != 0);
    bit          mis   = mem && ((addr % 32'(op_size(k))) != 0);
    bit          fwb;
    logic [31:0] ld;
    check_eq("idle_stall", 32'(stallreq_o), 32'd0);
    ex_valid_i      = 1'b1;
    ex_aluop_i      = mem ? op_code(k) : 8'($urandom_range(0, 31));
    ex_mem_addr_i   = addr;
    ex_store_data_i = sdata;
    ex_wdata_i      = alu;
    ex_waddr_i      = waddr;
    ex_wreg_i       = wreg;
    ex_pc_i         = pc;
    ex_excp_i       = exc;
    flush_i         = (fl == F_IDLE);
    dcache_resp_valid_i = ($urandom_range(0, 3) == 0);
    dcache_resp_data_i  = $urandom;
    step();
    ex_valid_i = 1'b0; ex_excp_i = 1'b0; flush_i = 1'b0; dcache_resp_valid_i = 1'b0;
    if (fl == F_IDLE) begin
      check_eq("flush_idle_wbv", 32'(wb_valid_o), 32'd0);
      check_eq("flush_idle_req", 32'(dcache_req_valid_o), 32'd0);
      return;
    end
    if (!mem || exc || mis) begin
      check_eq("direct_wbv", 32'(wb_valid_o), 32'd1);
      check_eq("direct_wreg", 32'(wb_wreg_o), 32'(wreg && !exc && !mis));
      check_eq("direct_waddr", 32'(wb_waddr_o), 32'(waddr));
      check_eq("direct_wdata", wb_wdata_o, alu);
      check_eq("direct_pc", wb_pc_o, pc);
      check_eq("direct_excp", 32'(wb_excp_o), 32'(exc || mis));
      check_eq("direct_ale", 32'(wb_ale_o), 32'(mis && !exc));
      check_eq("direct_fwdw", 32'(fwd_write_reg_o), 32'(wreg && !exc && !mis));
      check_eq("direct_fwdld", 32'(fwd_is_load_data_o), 32'd0);
      check_eq("direct_fwdd", fwd_wdata_o, alu);
      check_eq("direct_stall", 32'(stallreq_o), 32'd0);
      check_eq("direct_req", 32'(dcache_req_valid_o), 32'd0);
      return;
    end
    for (int i = 0; i <= rd; i++) begin
      check_eq("req_valid", 32'(dcache_req_valid_o), 32'd1);
      check_eq("req_stall", 32'(stallreq_o), 32'd1);
      check_eq("req_wbv", 32'(wb_valid_o), 32'd0);
      check_eq("req_we", 32'(dcache_req_we_o), 32'(op_store(k)));
      check_eq("req_addr", dcache_req_addr_o, addr - (addr % 4));
      if (op_store(k)) begin
        check_eq("req_wstrb", 32'(dcache_req_wstrb_o), 32'(exp_strb(k, addr)));
        check_eq("req_wdata", dcache_req_wdata_o, exp_wdata(k, sdata));
      end
      dcache_req_ready_i = (i == rd);
      flush_i = (fl == F_REQ_NOHS && i == fpos) || (fl == F_REQ_HS && i == rd);
      step();
      dcache_req_ready_i = 1'b0; flush_i = 1'b0;
      if (fl == F_REQ_NOHS && i == fpos) begin
        check_eq("reqflush_stall", 32'(stallreq_o), 32'd0);
        check_eq("reqflush_wbv", 32'(wb_valid_o), 32'd0);
        check_eq("reqflush_req", 32'(dcache_req_valid_o), 32'd0);
        return;
      end
    end
    if (op_store(k)) begin
      fwb = (fl != F_REQ_HS);
      check_eq("st_wbv", 32'(wb_valid_o), 32'(fwb));
      check_eq("st_stall", 32'(stallreq_o), 32'd0);
      check_eq("st_req", 32'(dcache_req_valid_o), 32'd0);
      if (fwb) begin
        check_eq("st_wreg", 32'(wb_wreg_o), 32'd0);
        check_eq("st_waddr", 32'(wb_waddr_o), 32'(waddr));
        check_eq("st_pc", wb_pc_o, pc);
        check_eq("st_excp", 32'(wb_excp_o), 32'd0);
        check_eq("st_fwdw", 32'(fwd_write_reg_o), 32'd0);
        check_eq("st_fwdld", 32'(fwd_is_load_data_o), 32'd0);
      end
      return;
    end
    for (int j = 0; j <= rsp_d; j++) begin
      check_eq("wait_stall", 32'(stallreq_o), 32'd1);
      check_eq("wait_req", 32'(dcache_req_valid_o), 32'd0);
      check_eq("wait_wbv", 32'(wb_valid_o), 32'd0);
      dcache_resp_valid_i = (j == rsp_d);
      dcache_resp_data_i  = (j == rsp_d) ? rword : $urandom;
      flush_i = (fl == F_WAIT && j == fpos) || (fl == F_WAIT_RESP && j == rsp_d);
      step();
      dcache_resp_valid_i = 1'b0; flush_i = 1'b0;
    end
    fwb = (fl == F_NONE);
    ld  = exp_load(k, addr, rword);
    check_eq("ld_wbv", 32'(wb_valid_o), 32'(fwb));
    check_eq("ld_stall", 32'(stallreq_o), 32'd0);
    if (fwb) begin
      check_eq("ld_wreg", 32'(wb_wreg_o), 32'(wreg));
      check_eq("ld_waddr", 32'(wb_waddr_o), 32'(waddr));
      check_eq("ld_wdata", wb_wdata_o, ld);
      check_eq("ld_pc", wb_pc_o, pc);
      check_eq("ld_excp", 32'(wb_excp_o), 32'd0);
      check_eq("ld_fwdld", 32'(fwd_is_load_data_o), 32'd1);
      check_eq("ld_fwdw", 32'(fwd_write_reg_o), 32'(wreg));
      check_eq("ld_fwdd", fwd_wdata_o, ld);
      check_eq("ld_fwda", 32'(fwd_waddr_o), 32'(waddr));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wbv"}, 32'(wb_valid_o), 32'd0);
    check_eq({tag, "_wbfields"}, 32'({wb_wreg_o, wb_waddr_o, wb_excp_o, wb_ale_o}), 32'd0);
    check_eq({tag, "_wbdata"}, wb_wdata_o | wb_pc_o, 32'd0);
    check_eq({tag, "_fwd"}, 32'({fwd_write_reg_o, fwd_is_load_data_o, fwd_waddr_o}) | fwd_wdata_o, 32'd0);
    check_eq({tag, "_req"}, 32'({dcache_req_valid_o, dcache_req_we_o, dcache_req_wstrb_o})
                            | dcache_req_addr_o | dcache_req_wdata_o, 32'd0);
    check_eq({tag, "_stall"}, 32'(stallreq_o), 32'd0);
  endtask

  initial begin
    int k, rd, rsp_d, fl, fpos;
    logic [31:0] a;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Directed cases from the test plan.
    run_txn(0, 1'b0, 32'h0, 32'h0, 32'h0000_1234, 32'h0, 0, 0, F_NONE, 0);
    run_txn(1, 1'b0, 32'h1003, 32'h0, 32'h0, 32'h80FF_FFFF, 0, 1, F_NONE, 0);
    run_txn(7, 1'b0, 32'h2002, 32'hABCD_1234, 32'h0, 32'h0, 3, 0, F_NONE, 0);
    run_txn(3, 1'b0, 32'h3001, 32'h0, 32'h5555_AAAA, 32'h0, 0, 0, F_NONE, 0);
    run_txn(5, 1'b0, 32'h4002, 32'h0, 32'h0, 32'hBEEF_0000, 0, 2, F_WAIT, 0);
    run_txn(0, 1'b0, 32'h0, 32'h0, 32'h0000_0042, 32'h0, 0, 0, F_NONE, 0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      k     = $urandom_range(0, 8);
      a     = $urandom;
      rd    = $urandom_range(0, 3);
      rsp_d = $urandom_range(0, 3);
      fl    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : F_NONE;
      fpos  = 0;
      if (fl == F_REQ_NOHS) begin
        if (rd == 0) fl = F_NONE;
        else fpos = $urandom_range(0, rd - 1);
      end
      if ((fl == F_WAIT || fl == F_WAIT_RESP) && !op_load(k)) fl = F_NONE;
      if (fl == F_WAIT) begin
        if (rsp_d == 0) fl = F_WAIT_RESP;
        else fpos = $urandom_range(0, rsp_d - 1);
      end
      run_txn(k, ($urandom_range(0, 7) == 0), a, $urandom, $urandom, $urandom, rd, rsp_d, fl, fpos);
      if ($urandom_range(0, 1) == 1) begin
        step();
        check_eq("gap_wbv", 32'(wb_valid_o), 32'd0);
      end
    end

    // Reset while a load waits for its response; the late response must be ignored.
    ex_valid_i = 1'b1; ex_aluop_i = 8'h22; ex_mem_addr_i = 32'h5000; ex_excp_i = 1'b0;
    step();
    ex_valid_i = 1'b0; dcache_req_ready_i = 1'b1;
    step();
    dcache_req_ready_i = 1'b0;
    check_eq("rst_wait_stall", 32'(stallreq_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rst_mid");
    dcache_resp_valid_i = 1'b1; dcache_resp_data_i = 32'hDEAD_BEEF;
    step();
    dcache_resp_valid_i = 1'b0;
    check_eq("late_resp_wbv", 32'(wb_valid_o), 32'd0);
    check_eq("late_resp_stall", 32'(stallreq_o), 32'd0);
    run_txn(0, 1'b0, 32'h0, 32'h0, 32'h0000_0777, 32'h0, 0, 0, F_NONE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
